// File: rtl/adder_pkg.sv
// Shared types and constants for the pipelined adder.
// The stage record is sized for the widest legal operand so one typedef
// serves every WIDTH; instances use only the low WIDTH bits.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;
    localparam int MAX_WIDTH      = 64;

    // Bits added per pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // One pipeline stage record. Operand chunks not yet added ride along in
    // a/b, finished low sum chunks ride along in psum, and carry is the chunk
    // carry handed to the next stage (the final carry-out at the last stage).
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 sub;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic [MAX_WIDTH-1:0] psum;
    } stage_rec_t;

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple-carry adder with carry-in and carry-out;
// one instance per pipeline stage.
module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Ripple the carry bit by bit through the chunk.
    always_comb begin
        logic [W:0] c;
        // NOTE: every output of a combinational block gets a default before
        // any conditional or looped assignment, so no path can infer a latch.
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[W];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: {cout,sum} = a + b + cin, computed CHUNK bits per
// stage over STAGES registered stages, with a valid/ready handshake on both
// sides. The whole pipeline advances together and stalls together when the
// output is held.
//
// Optional feature: define PIPELINED_ADDER_SUB_EN to add the `sub` input.
// With sub=1 the beat computes a + ~b + 1 (cin ignored); cout=1 then means
// no borrow, and ovf is judged against the inverted b.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    // Reject configurations the chunk slicing cannot represent.
    if (STAGES < 1 || WIDTH < 4 || WIDTH > MAX_WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be 4..64 and a multiple of STAGES");
    end

    stage_rec_t stage_q [STAGES];  // registered record after each stage
    stage_rec_t stage_in [STAGES]; // record entering each stage's adder
    stage_rec_t stage_d [STAGES];  // record leaving each stage's adder

    logic [STAGES-1:0][CHUNK-1:0] chunk_a;
    logic [STAGES-1:0][CHUNK-1:0] chunk_b;
    logic [STAGES-1:0][CHUNK-1:0] chunk_s;
    logic [STAGES-1:0]            chunk_ci;
    logic [STAGES-1:0]            chunk_co;

    logic adv;
    logic beat_sub;

`ifdef PIPELINED_ADDER_SUB_EN
    assign beat_sub = sub;
`else
    assign beat_sub = 1'b0;
`endif

    // The pipeline moves whenever the output slot is empty or being drained.
    assign adv      = !stage_q[LAST].valid || out_ready;
    assign in_ready = adv;

    // Build the incoming record from the port beat and chain the rest from
    // the previous stage's register; subtract folds into b and the carry-in.
    always_comb begin
        stage_in[0]                = '0;
        stage_in[0].valid          = in_valid;
        stage_in[0].sub            = beat_sub;
        stage_in[0].a[WIDTH-1:0]   = a;
        stage_in[0].b[WIDTH-1:0]   = beat_sub ? ~b : b;
        stage_in[0].carry          = beat_sub ? 1'b1 : cin;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

    // One ripple adder per stage, each working on its own chunk.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign chunk_a[g]  = stage_in[g].a[g*CHUNK +: CHUNK];
        assign chunk_b[g]  = stage_in[g].b[g*CHUNK +: CHUNK];
        assign chunk_ci[g] = stage_in[g].carry;

        add_chunk #(
            .W (CHUNK)
        ) u_add_chunk (
            .a  (chunk_a[g]),
            .b  (chunk_b[g]),
            .ci (chunk_ci[g]),
            .s  (chunk_s[g]),
            .co (chunk_co[g])
        );
    end

    // Merge each stage's chunk sum and carry into the record it passes on.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k]                         = stage_in[k];
            stage_d[k].psum[k*CHUNK +: CHUNK]  = chunk_s[k];
            stage_d[k].carry                   = chunk_co[k];
        end
    end

    // Stage registers: cleared by reset, otherwise advance in lock-step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the records are cleared in full, not just their valid bits,
            // because the output fields must read zero straight after reset.
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            // NOTE: sequential state is assigned non-blocking so every stage
            // samples its predecessor's pre-edge value.
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[LAST].valid;
    assign sum       = stage_q[LAST].psum[WIDTH-1:0];
    assign cout      = stage_q[LAST].carry;
    // b already holds the operand actually added, so this covers subtract too.
    assign ovf       = (stage_q[LAST].a[WIDTH-1] == stage_q[LAST].b[WIDTH-1]) &&
                       (stage_q[LAST].psum[WIDTH-1] != stage_q[LAST].a[WIDTH-1]);

endmodule
